// File: rtl/mm_mem_pkg.sv
// Shared types and constants for the matrix-multiplier memory: FSM encoding,
// host preload select codes and header slot indices.
package mm_mem_pkg;

  typedef enum logic [1:0] {
    StLoad  = 2'd0,
    StServe = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam logic [1:0] LdSelHdr = 2'd0;
  localparam logic [1:0] LdSelA   = 2'd1;
  localparam logic [1:0] LdSelB   = 2'd2;
  localparam logic [1:0] LdSelGo  = 2'd3;

  localparam logic [1:0] HdrM1Row = 2'd0;
  localparam logic [1:0] HdrM1Col = 2'd1;
  localparam logic [1:0] HdrM2Col = 2'd2;

  localparam int unsigned AddrW = 20;
  localparam int unsigned CntW  = 5;
  localparam logic [CntW-1:0] CntMax = '1;

  function automatic logic idx_ok(logic [AddrW-1:0] idx, int unsigned dim);
    return idx < AddrW'(dim);
  endfunction

endpackage

// File: rtl/mm_mem_if.sv
// Bus between the multiplier/host (master) and the matrix memory (slave).
interface mm_mem_if #(
  parameter int unsigned DW = 20
);

  logic [mm_mem_pkg::AddrW-1:0] i;
  logic [mm_mem_pkg::AddrW-1:0] j;
  logic                         read;
  logic                         write;
  logic                         index;
  logic [DW-1:0]                read_data;
  logic [2*DW-1:0]              write_data;
  logic                         finish;
  logic                         ld_valid;
  logic [1:0]                   ld_sel;
  logic [1:0]                   ld_i;
  logic [1:0]                   ld_j;
  logic [DW-1:0]                ld_data;
  logic                         ld_ready;
  logic [1:0]                   res_i;
  logic [1:0]                   res_j;
  logic [2*DW-1:0]              res_data;
  logic                         done;
  logic                         err;
  logic [mm_mem_pkg::CntW-1:0]  wr_count;

  modport master (
    output i, j, read, write, index, write_data, finish,
    output ld_valid, ld_sel, ld_i, ld_j, ld_data, res_i, res_j,
    input  read_data, ld_ready, res_data, done, err, wr_count
  );

  modport slave (
    input  i, j, read, write, index, write_data, finish,
    input  ld_valid, ld_sel, ld_i, ld_j, ld_data, res_i, res_j,
    output read_data, ld_ready, res_data, done, err, wr_count
  );

endinterface

// File: rtl/mm_mem_bank.sv
// Dim x Dim register-file matrix: one synchronous write port, two combinational
// read ports. Callers keep row/col below Dim.
module mm_mem_bank #(
  parameter int unsigned Width = 20,
  parameter int unsigned Dim   = 4,
  parameter int unsigned IdxW  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [IdxW-1:0]  wrow_i,
  input  logic [IdxW-1:0]  wcol_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [IdxW-1:0]  rrow0_i,
  input  logic [IdxW-1:0]  rcol0_i,
  output logic [Width-1:0] rdata0_o,
  input  logic [IdxW-1:0]  rrow1_i,
  input  logic [IdxW-1:0]  rcol1_i,
  output logic [Width-1:0] rdata1_o
);

  logic [Width-1:0] mem_q [Dim][Dim];
  logic [Width-1:0] mem_d [Dim][Dim];

  always_comb begin
    mem_d = mem_q;
    if (we_i) mem_d[wrow_i][wcol_i] = wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  assign rdata0_o = mem_q[rrow0_i][rcol0_i];
  assign rdata1_o = mem_q[rrow1_i][rcol1_i];

endmodule

// File: rtl/mm_mem.sv
// Operand/result store for a matrix multiplier: host preloads header, A and B,
// the multiplier then reads operands and writes C until complete.
module mm_mem
  import mm_mem_pkg::*;
#(
  parameter int unsigned MAX_DIM = 4,
  parameter int unsigned DW      = 20
) (
  input logic    clk,
  input logic    reset,
  mm_mem_if.slave bus
);

  localparam int unsigned IdxW = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam int unsigned RW   = 2 * DW;

  state_e          state_q, state_d;
  logic [DW-1:0]   hdr_q [3];
  logic [DW-1:0]   hdr_d [3];
  logic [CntW-1:0] wr_count_q, wr_count_d;
  logic            err_q, err_d;

  logic [AddrW-1:0] ld_row, ld_col, res_row, res_col;
  logic             in_range, ld_ok, res_ok;
  logic             ld_fire, a_we, b_we, c_we, cnt_inc, reach;
  logic [CntW-1:0]  cnt_next;
  logic [RW-1:0]    target;
  logic [DW-1:0]    a_rd, b_rd, hdr_rd, a_rd_unused, b_rd_unused;
  logic [RW-1:0]    c_rd, c_rd_unused;

  assign ld_row  = AddrW'(bus.ld_i);
  assign ld_col  = AddrW'(bus.ld_j);
  assign res_row = AddrW'(bus.res_i);
  assign res_col = AddrW'(bus.res_j);

  assign in_range = idx_ok(bus.i, MAX_DIM) && idx_ok(bus.j, MAX_DIM);
  assign ld_ok    = idx_ok(ld_row, MAX_DIM) && idx_ok(ld_col, MAX_DIM);
  assign res_ok   = idx_ok(res_row, MAX_DIM) && idx_ok(res_col, MAX_DIM);

  assign ld_fire  = (state_q == StLoad) && bus.ld_valid;
  assign a_we     = ld_fire && (bus.ld_sel == LdSelA) && ld_ok;
  assign b_we     = ld_fire && (bus.ld_sel == LdSelB) && ld_ok;
  assign c_we     = (state_q == StServe) && bus.write && !bus.read && in_range;
  assign cnt_inc  = c_we && (wr_count_q != CntMax);
  assign cnt_next = wr_count_q + CntW'(1);

  // Completion only on the write that makes the count equal the result size.
  assign target = RW'(hdr_q[HdrM1Row]) * RW'(hdr_q[HdrM2Col]);
  assign reach  = cnt_inc && (target != '0) && (target == RW'(cnt_next));

  mm_mem_bank #(.Width(DW), .Dim(MAX_DIM), .IdxW(IdxW)) u_bank_a (
    .clk      (clk),
    .rst_n    (reset),
    .we_i     (a_we),
    .wrow_i   (ld_row[IdxW-1:0]),
    .wcol_i   (ld_col[IdxW-1:0]),
    .wdata_i  (bus.ld_data),
    .rrow0_i  (bus.i[IdxW-1:0]),
    .rcol0_i  (bus.j[IdxW-1:0]),
    .rdata0_o (a_rd),
    .rrow1_i  (res_row[IdxW-1:0]),
    .rcol1_i  (res_col[IdxW-1:0]),
    .rdata1_o (a_rd_unused)
  );

  mm_mem_bank #(.Width(DW), .Dim(MAX_DIM), .IdxW(IdxW)) u_bank_b (
    .clk      (clk),
    .rst_n    (reset),
    .we_i     (b_we),
    .wrow_i   (ld_row[IdxW-1:0]),
    .wcol_i   (ld_col[IdxW-1:0]),
    .wdata_i  (bus.ld_data),
    .rrow0_i  (bus.i[IdxW-1:0]),
    .rcol0_i  (bus.j[IdxW-1:0]),
    .rdata0_o (b_rd),
    .rrow1_i  (res_row[IdxW-1:0]),
    .rcol1_i  (res_col[IdxW-1:0]),
    .rdata1_o (b_rd_unused)
  );

  mm_mem_bank #(.Width(RW), .Dim(MAX_DIM), .IdxW(IdxW)) u_bank_c (
    .clk      (clk),
    .rst_n    (reset),
    .we_i     (c_we),
    .wrow_i   (bus.i[IdxW-1:0]),
    .wcol_i   (bus.j[IdxW-1:0]),
    .wdata_i  (bus.write_data),
    .rrow0_i  (res_row[IdxW-1:0]),
    .rcol0_i  (res_col[IdxW-1:0]),
    .rdata0_o (c_rd),
    .rrow1_i  (bus.i[IdxW-1:0]),
    .rcol1_i  (bus.j[IdxW-1:0]),
    .rdata1_o (c_rd_unused)
  );

  always_comb begin
    hdr_rd = '0;
    if (bus.i <= AddrW'(HdrM2Col)) begin
      case (bus.i[1:0])
        HdrM1Row: hdr_rd = hdr_q[HdrM1Row];
        HdrM1Col: hdr_rd = hdr_q[HdrM1Col];
        HdrM2Col: hdr_rd = hdr_q[HdrM2Col];
        default:  hdr_rd = '0;
      endcase
    end
  end

  always_comb begin
    bus.read_data = '0;
    if (reset && (state_q != StLoad) && bus.read && in_range) begin
      bus.read_data = bus.write ? hdr_rd : (bus.index ? b_rd : a_rd);
    end
  end

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    wr_count_d = wr_count_q;
    err_d      = err_q;
    unique case (state_q)
      StLoad: begin
        if (bus.ld_valid) begin
          case (bus.ld_sel)
            LdSelHdr: begin
              case (bus.ld_j)
                HdrM1Row: hdr_d[HdrM1Row] = bus.ld_data;
                HdrM1Col: hdr_d[HdrM1Col] = bus.ld_data;
                HdrM2Col: hdr_d[HdrM2Col] = bus.ld_data;
                default:  ;
              endcase
            end
            LdSelGo: state_d = StServe;
            default: ;
          endcase
        end
      end
      StServe: begin
        if ((bus.read || bus.write) && !in_range) err_d = 1'b1;
        if (cnt_inc) wr_count_d = cnt_next;
        if (bus.finish || reach) state_d = StDone;
      end
      StDone:  ;
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StLoad;
      hdr_q      <= '{default: '0};
      wr_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      wr_count_q <= wr_count_d;
      err_q      <= err_d;
    end
  end

  // ld_ready must drop the instant reset asserts, not just after LOAD is forced.
  assign bus.ld_ready = reset && (state_q == StLoad);
  assign bus.res_data = (reset && res_ok) ? c_rd : '0;
  assign bus.done     = (state_q == StDone);
  assign bus.err      = err_q;
  assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_mm_mem.sv
// Directed bench for mm_mem: a behavioural model of the store is compared on
// every falling edge, plus hand-computed expectations at key points.
module tb_mm_mem;

  localparam int MAX_DIM = 4;
  localparam int DW      = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mm_mem_if #(.DW(DW)) bus ();

  mm_mem #(.MAX_DIM(MAX_DIM), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: 0 = loading, 1 = serving, 2 = done
  logic [DW-1:0]   m_hdr [3];
  logic [DW-1:0]   m_a [4][4];
  logic [DW-1:0]   m_b [4][4];
  logic [2*DW-1:0] m_c [4][4];
  int              m_cnt;
  bit              m_err;
  int              m_state;

  task automatic m_clear();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        m_a[r][c] = '0;
        m_b[r][c] = '0;
        m_c[r][c] = '0;
      end
    end
    for (int h = 0; h < 3; h++) m_hdr[h] = '0;
    m_cnt   = 0;
    m_err   = 1'b0;
    m_state = 0;
  endtask

  function automatic bit m_oob();
    return (int'(bus.i) >= MAX_DIM) || (int'(bus.j) >= MAX_DIM);
  endfunction

  task automatic m_step();
    logic [1:0] ii, jj;
    longint     prod;
    ii = bus.i[1:0];
    jj = bus.j[1:0];
    if (m_state == 0) begin
      if (bus.ld_valid) begin
        case (bus.ld_sel)
          2'd0: if (bus.ld_j < 2'd3) m_hdr[bus.ld_j] = bus.ld_data;
          2'd1: m_a[bus.ld_i][bus.ld_j] = bus.ld_data;
          2'd2: m_b[bus.ld_i][bus.ld_j] = bus.ld_data;
          default: m_state = 1;
        endcase
      end
    end else if (m_state == 1) begin
      prod = longint'(m_hdr[0]) * longint'(m_hdr[2]);
      if ((bus.read || bus.write) && m_oob()) m_err = 1'b1;
      if (bus.write && !bus.read && !m_oob()) begin
        m_c[ii][jj] = bus.write_data;
        if (m_cnt < 31) begin
          m_cnt++;
          if (longint'(m_cnt) == prod) m_state = 2;
        end
      end
      if (bus.finish) m_state = 2;
    end
  endtask

  function automatic logic [DW-1:0] m_read();
    if (!reset || m_state == 0 || !bus.read || m_oob()) return '0;
    if (bus.write) return (int'(bus.i) < 3) ? m_hdr[bus.i[1:0]] : '0;
    return bus.index ? m_b[bus.i[1:0]][bus.j[1:0]] : m_a[bus.i[1:0]][bus.j[1:0]];
  endfunction

  initial begin
    m_clear();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) m_clear();
      else        m_step();
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("read_data", 64'(bus.read_data), 64'(m_read()));
      chk("ld_ready", 64'(bus.ld_ready), 64'(reset && m_state == 0));
      chk("res_data", 64'(bus.res_data), reset ? 64'(m_c[bus.res_i][bus.res_j]) : 64'(0));
      chk("done", 64'(bus.done), 64'(m_state == 2));
      chk("err", 64'(bus.err), 64'(m_err));
      chk("wr_count", 64'(bus.wr_count), 64'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i = '0; bus.j = '0; bus.read = 1'b0; bus.write = 1'b0; bus.index = 1'b0;
    bus.write_data = '0; bus.finish = 1'b0; bus.ld_valid = 1'b0; bus.ld_sel = '0;
    bus.ld_i = '0; bus.ld_j = '0; bus.ld_data = '0; bus.res_i = '0; bus.res_j = '0;
  endtask

  task automatic ld(input int sel, input int li, input int lj, input logic [DW-1:0] d);
    bus.ld_valid = 1'b1;
    bus.ld_sel = 2'(sel); bus.ld_i = 2'(li); bus.ld_j = 2'(lj); bus.ld_data = d;
    tick();
    bus.ld_valid = 1'b0;
  endtask

  task automatic wr(input int wi, input int wj, input logic [2*DW-1:0] d, input bit fin);
    bus.read = 1'b0; bus.write = 1'b1; bus.finish = fin;
    bus.i = 20'(wi); bus.j = 20'(wj); bus.write_data = d;
    tick();
    bus.write = 1'b0; bus.finish = 1'b0;
  endtask

  task automatic rd(input bit hdr, input bit idx, input int ri, input int rj);
    bus.read = 1'b1; bus.write = hdr; bus.index = idx;
    bus.i = 20'(ri); bus.j = 20'(rj);
  endtask

  task automatic load_hdr(input int r, input int c, input int k);
    ld(0, 0, 0, 20'(r));
    ld(0, 0, 1, 20'(c));
    ld(0, 0, 2, 20'(k));
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #3 reset = 1'b0;
    check_en = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_ld_ready", 64'(bus.ld_ready), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rel_ld_ready", 64'(bus.ld_ready), 64'(1));
    tick();

    load_hdr(2, 2, 2);
    ld(1, 0, 0, 20'd1); ld(1, 0, 1, 20'd2); ld(1, 1, 0, 20'd3); ld(1, 1, 1, 20'd4);
    ld(2, 0, 0, 20'd5); ld(2, 0, 1, 20'hFFFFB); ld(2, 1, 0, 20'd7); ld(2, 1, 1, 20'd8);
    ld(3, 0, 0, 20'd0);
    @(negedge clk);
    chk("serve_ld_ready", 64'(bus.ld_ready), 64'(0));

    // Header reads, including the slot past m2_col
    rd(1'b1, 1'b0, 1, 0);
    @(negedge clk);
    chk("s1_hdr1", 64'(bus.read_data), 64'(2));
    tick();
    rd(1'b1, 1'b0, 3, 0);
    @(negedge clk);
    chk("s1_hdr3", 64'(bus.read_data), 64'(0));
    tick();

    rd(1'b0, 1'b1, 0, 1);
    @(negedge clk);
    chk("s2_b01", 64'(bus.read_data), 64'h0FFFFB);
    tick();
    rd(1'b0, 1'b0, 1, 1);
    @(negedge clk);
    chk("s2_a11", 64'(bus.read_data), 64'(4));
    tick();

    // Preload port is dead outside LOAD
    bus.read = 1'b0;
    ld(1, 0, 0, 20'd99);
    rd(1'b0, 1'b0, 0, 0);
    @(negedge clk);
    chk("serve_ld_ignored", 64'(bus.read_data), 64'(1));
    tick();

    wr(5, 0, 40'd123, 1'b0);
    bus.res_i = 2'd0; bus.res_j = 2'd0;
    @(negedge clk);
    chk("s4_err", 64'(bus.err), 64'(1));
    chk("s4_cnt", 64'(bus.wr_count), 64'(0));
    chk("s4_c00", 64'(bus.res_data), 64'(0));
    rd(1'b0, 1'b0, 0, 4);
    tick();

    wr(0, 0, 40'd19, 1'b0);
    wr(0, 1, 40'd22, 1'b0);
    wr(1, 0, 40'd43, 1'b0);
    @(negedge clk);
    chk("s3_cnt3", 64'(bus.wr_count), 64'(3));
    chk("s3_notdone", 64'(bus.done), 64'(0));
    wr(1, 1, 40'd50, 1'b0);
    bus.res_i = 2'd1; bus.res_j = 2'd1;
    @(negedge clk);
    chk("s3_cnt4", 64'(bus.wr_count), 64'(4));
    chk("s3_done", 64'(bus.done), 64'(1));
    chk("s3_c11", 64'(bus.res_data), 64'(50));

    wr(0, 0, 40'd77, 1'b0);
    bus.res_i = 2'd0; bus.res_j = 2'd0;
    rd(1'b0, 1'b0, 1, 0);
    @(negedge clk);
    chk("done_wr_ignored", 64'(bus.res_data), 64'(19));
    chk("done_cnt", 64'(bus.wr_count), 64'(4));
    chk("done_read", 64'(bus.read_data), 64'(3));
    tick();
    idle();

    reset = 1'b0;
    tick();
    reset = 1'b1;
    load_hdr(3, 3, 3);
    ld(3, 0, 0, 20'd0);
    wr(0, 0, 40'd5, 1'b0);
    wr(0, 0, 40'd6, 1'b0);
    @(negedge clk);
    chk("rewrite_cnt", 64'(bus.wr_count), 64'(2));
    chk("rewrite_c00", 64'(bus.res_data), 64'(6));
    #2 reset = 1'b0;
    rd(1'b0, 1'b0, 0, 0);
    #1;
    chk("s6_done", 64'(bus.done), 64'(0));
    chk("s6_cnt", 64'(bus.wr_count), 64'(0));
    chk("s6_res", 64'(bus.res_data), 64'(0));
    chk("s6_ld_ready_low", 64'(bus.ld_ready), 64'(0));
    chk("s6_read_data", 64'(bus.read_data), 64'(0));
    tick();
    reset = 1'b1;
    idle();
    @(negedge clk);
    chk("s6_ld_ready", 64'(bus.ld_ready), 64'(1));
    tick();

    // Result size 36 is never reached, so the count must pin at 31
    load_hdr(6, 1, 6);
    ld(3, 0, 0, 20'd0);
    for (int k = 0; k < 33; k++) wr(k % 4, (k / 4) % 4, 40'(k + 1), 1'b0);
    @(negedge clk);
    chk("sat_cnt", 64'(bus.wr_count), 64'(31));
    chk("sat_notdone", 64'(bus.done), 64'(0));
    wr(0, 0, 40'hFFFFFFFFFF, 1'b1);
    bus.res_i = 2'd0; bus.res_j = 2'd0;
    @(negedge clk);
    chk("s5_done", 64'(bus.done), 64'(1));
    chk("s5_c00", 64'(bus.res_data), 64'hFFFFFFFFFF);
    tick();

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mm_mem.md
MM_MEM -- requirements
Module: mm_mem

Interface
REQ-001 Parameter MAX_DIM, default 4, SHALL set the maximum row/column count of every stored matrix.
REQ-002 Parameter DW, default 20, SHALL set the operand width; result width SHALL be 2*DW.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 i  in  20  row address from the multiplier.
REQ-006 j  in  20  column address from the multiplier.
REQ-007 read  in  1  read strobe.
REQ-008 write  in  1  write strobe.
REQ-009 index  in  1  matrix select for operand reads; 0 selects A, 1 selects B.
REQ-010 read_data  out  DW  combinational read response.
REQ-011 write_data  in  2*DW  result word.
REQ-012 finish  in  1  multiplier completion flag.
REQ-013 ld_valid, ld_sel[1:0], ld_i[1:0], ld_j[1:0], ld_data[DW-1:0]  in  host preload port.
REQ-014 ld_ready  out  1  preload accepted this cycle.
REQ-015 res_i[1:0], res_j[1:0]  in; res_data[2*DW-1:0]  out  result readback.
REQ-016 done, err  out  1 each; wr_count  out  5  accepted result writes.

Function
REQ-017 The FSM SHALL have three states: LOAD, SERVE and DONE; reset SHALL enter LOAD.
REQ-018 LOAD: ld_ready SHALL be 1; a ld_valid cycle SHALL write one location per ld_sel.
- ld_sel 0: header[ld_j], where 0 is m1_row, 1 is m1_col, 2 is m2_col.
- ld_sel 1: A[ld_i][ld_j].
- ld_sel 2: B[ld_i][ld_j].
- ld_sel 3 (go): the FSM SHALL move to SERVE on the next edge; ld_data is ignored.
REQ-019 In SERVE and DONE, ld_ready SHALL be 0 and ld_valid SHALL be ignored.
REQ-020 read_data SHALL be zero-latency combinational and SHALL be valid in the same cycle as the strobe.
- read=1, write=1: header[i]; i>2 returns 0.
- read=1, write=0, index=0: A[i][j].
- read=1, write=0, index=1: B[i][j].
- Otherwise, and whenever the FSM is in LOAD: 0.
REQ-021 SERVE, write=1, read=0: C[i][j] SHALL take write_data on the next edge and wr_count SHALL increment.
REQ-022 A rewrite of an already-written C location SHALL overwrite it and SHALL still increment wr_count.
REQ-023 An i or j >= MAX_DIM on any SERVE access SHALL set err (sticky); such reads SHALL return 0 and such writes SHALL be dropped without counting.
REQ-024 SERVE SHALL go to DONE on the edge after finish=1, or on the edge at which wr_count reaches m1_row*m2_col (nonzero product only).
REQ-025 A write in the same cycle as the DONE trigger SHALL be captured.
REQ-026 DONE: done=1; writes SHALL be ignored; reads SHALL still be served; DONE SHALL be exited only by reset.
REQ-027 res_data SHALL equal C[res_i][res_j] combinationally in every state.
REQ-028 wr_count SHALL saturate at 31.

Reset
REQ-029 Asserting reset (low) SHALL clear header, A, B, C, wr_count, err and done to 0 and force LOAD, asynchronously, including mid-SERVE.
REQ-030 While reset is low: read_data SHALL be 0, ld_ready 0, res_data 0.
REQ-031 After reset is released, ld_ready SHALL be 1 from the first clock.

Structure
REQ-032 A shared package SHALL hold the state encoding (LOAD=0, SERVE=1, DONE=2), the ld_sel codes and the header index constants.
REQ-033 The storage SHALL be one sub-module, mm_mem_bank, instantiated three times: A and B at DW width, C at 2*DW width.
- Each instance has one synchronous write port and two combinational read ports.

Verification
REQ-034 Scenario 1: load header 2,2,2 and A=[[1,2],[3,4]], then go; read=1, write=1, i=1 -> read_data=2 in the same cycle.
REQ-035 Scenario 2: in SERVE, read=1, write=0, index=1, i=0, j=1 with B[0][1]=-5 -> read_data=20'hFFFFB.
REQ-036 Scenario 3: four writes to C[0..1][0..1] with 19, 22, 43, 50 -> wr_count=4, done=1 on the next edge, res_data at (1,1)=50.
REQ-037 Scenario 4: write with i=5 -> err=1, wr_count unchanged, C unchanged.
REQ-038 Scenario 5: finish=1 together with a write of 40'hFFFFFFFFFF to C[0][0] -> location captured and done=1 on the same edge.
REQ-039 Scenario 6: reset low after two writes -> done=0, wr_count=0, res_data=0, ld_ready=1 after release.
